// File: rtl/oflow_ida_pkg.sv
// Shared core dimensions and the ID-assign FSM state encoding used by the
// score-board ID assignment logic.
package oflow_ida_pkg;

    localparam int ROW_LEN                    = 2;
    localparam int PE_LEN                     = 2;
    localparam int ID_LEN                     = 8;
    localparam int SCORE_LEN                  = 16;
    localparam int PE_NUM                     = 4;
    localparam int MAX_ROWS_IN_SCORE_BOARD    = 4;
    localparam int NUM_OF_BBOX_IN_FRAME_WIDTH = 5;

    typedef enum logic [1:0] {
        idle_st = 2'd0,
        read_st = 2'd1,
        emit_st = 2'd2,
        done_st = 2'd3
    } ida_state_t;

endpackage

// File: rtl/oflow_id_allocator.sv
// Fresh-ID counter: hands out next_id and advances on alloc, persisting
// across frames and skipping zero on wrap (zero marks an empty board slot).
module oflow_id_allocator
    import oflow_ida_pkg::*;
(
    input  logic              clk,
    input  logic              reset_N,
    input  logic              alloc,
    output logic [ID_LEN-1:0] next_id
);

    logic [ID_LEN-1:0] r_next_id;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_next_id <= ID_LEN'(1);
        end else if (alloc) begin
            r_next_id <= (&r_next_id) ? ID_LEN'(1) : r_next_id + 1'b1;
        end
    end

    assign next_id = r_next_id;

endmodule

// File: rtl/oflow_id_assign_fsm.sv
// Walks the score board row by row, turning each valid entry into an
// (id, new-id flag) result on a valid/ready stream; one box per two cycles.
module oflow_id_assign_fsm
    import oflow_ida_pkg::*;
#(
    parameter logic [SCORE_LEN-1:0] SCORE_TH = 16'hFFF0
)(
    input  logic                                  clk,
    input  logic                                  reset_N,
    input  logic                                  start_ida,
    input  logic                                  conflict_counter_th,
    output logic [ROW_LEN-1:0]                    row_sel,
    output logic [PE_LEN-1:0]                     pe_sel,
    input  logic [ID_LEN-1:0]                     id_in,
    input  logic [SCORE_LEN-1:0]                  score_in,
    input  logic                                  ptr_in,
    output logic [ID_LEN-1:0]                     id_out,
    output logic                                  new_id_flg,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  done_ida,
    output logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0] bbox_count
);

    ida_state_t r_state;
    ida_state_t w_next_state;

    logic [ROW_LEN-1:0]                    r_row;
    logic [PE_LEN-1:0]                     r_pe;
    logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0] r_bbox_count;
    logic [ID_LEN-1:0]                     r_id_out;
    logic                                  r_new_id;
    logic                                  r_conflict;
    logic                                  r_out_valid;
    logic                                  r_done;

    logic              w_start;
    logic              w_capture;
    logic              w_new_id;
    logic              w_alloc;
    logic              w_fire;
    logic              w_pe_last;
    logic              w_row_last;
    logic [ID_LEN-1:0] w_next_id;

    oflow_id_allocator u_id_allocator (
        .clk     (clk),
        .reset_N (reset_N),
        .alloc   (w_alloc),
        .next_id (w_next_id)
    );

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state <= idle_st;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A match is rejected (fresh ID) on a pointer hit, a poor score, or when
    // conflict resolution overflowed for this frame.
    always_comb begin
        w_next_state = r_state;
        w_start      = (r_state == idle_st) && start_ida;
        w_capture    = (r_state == read_st) && (id_in != '0);
        w_new_id     = ptr_in || (score_in >= SCORE_TH) || r_conflict;
        w_alloc      = w_capture && w_new_id;
        w_fire       = (r_state == emit_st) && out_ready;
        w_pe_last    = (r_pe == PE_LEN'(PE_NUM - 1));
        w_row_last   = (r_row == ROW_LEN'(MAX_ROWS_IN_SCORE_BOARD - 1));
        case (r_state)
            idle_st: if (start_ida) w_next_state = read_st;
            read_st: w_next_state = (id_in == '0) ? done_st : emit_st;
            emit_st: if (out_ready) w_next_state = (w_pe_last && w_row_last) ? done_st : read_st;
            done_st: w_next_state = idle_st;
            default: w_next_state = idle_st;
        endcase
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_row        <= '0;
            r_pe         <= '0;
            r_bbox_count <= '0;
            r_id_out     <= '0;
            r_new_id     <= 1'b0;
            r_conflict   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_out_valid <= (w_next_state == emit_st);
            r_done      <= (w_next_state == done_st);
            if (w_start) begin
                r_row        <= '0;
                r_pe         <= '0;
                r_bbox_count <= '0;
                r_conflict   <= conflict_counter_th;
            end
            if (w_capture) begin
                r_id_out <= w_new_id ? w_next_id : id_in;
                r_new_id <= w_new_id;
            end
            if (w_fire) begin
                r_bbox_count <= r_bbox_count + 1'b1;
                if (w_pe_last) begin
                    r_pe  <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_pe <= r_pe + 1'b1;
                end
            end
        end
    end

    assign row_sel    = r_row;
    assign pe_sel     = r_pe;
    assign id_out     = r_id_out;
    assign new_id_flg = r_new_id;
    assign out_valid  = r_out_valid;
    assign done_ida   = r_done;
    assign bbox_count = r_bbox_count;

endmodule

// File: tb/tb_oflow_id_assign_fsm.sv
// Randomized bench for oflow_id_assign_fsm: a score-board model feeds the DUT and
// a frame-level reference predicts every emitted (id, new-id flag) result.
module tb_oflow_id_assign_fsm;
    import oflow_ida_pkg::*;

    localparam int NENT  = PE_NUM * MAX_ROWS_IN_SCORE_BOARD;
    localparam int MAXID = (1 << ID_LEN) - 1;
    localparam logic [SCORE_LEN-1:0] TH = 16'hFFF0;

    logic clk = 1'b0;
    logic reset_N = 1'b0;
    logic start_ida = 1'b0;
    logic conflict_counter_th = 1'b0;
    logic out_ready = 1'b1;
    logic [ROW_LEN-1:0] row_sel;
    logic [PE_LEN-1:0] pe_sel;
    logic [ID_LEN-1:0] id_in;
    logic [ID_LEN-1:0] id_out;
    logic [SCORE_LEN-1:0] score_in;
    logic ptr_in;
    logic new_id_flg;
    logic out_valid;
    logic done_ida;
    logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0] bbox_count;

    logic [ID_LEN-1:0]    bId    [NENT];
    logic [SCORE_LEN-1:0] bScore [NENT];
    logic                 bPtr   [NENT];
    int boardIdx;

    int checks = 0;
    int failures = 0;
    int readyMode = 0;
    int stallCnt = 0;
    int modelNext = 1;
    logic [8:0] expQ[$];
    logic [8:0] capLog[$];
    int newIds[$];

    logic prevStall = 1'b0;
    logic [ID_LEN-1:0] prevId;
    logic [PE_LEN-1:0] prevPe;

    oflow_id_assign_fsm #(.SCORE_TH(16'hFFF0)) dut (
        .clk                 (clk),
        .reset_N             (reset_N),
        .start_ida           (start_ida),
        .conflict_counter_th (conflict_counter_th),
        .row_sel             (row_sel),
        .pe_sel              (pe_sel),
        .id_in               (id_in),
        .score_in            (score_in),
        .ptr_in              (ptr_in),
        .id_out              (id_out),
        .new_id_flg          (new_id_flg),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .done_ida            (done_ida),
        .bbox_count          (bbox_count)
    );

    always #5 clk = ~clk;

    // Score board read port: combinational data for the current address.
    assign boardIdx = int'(row_sel) * PE_NUM + int'(pe_sel);
    assign id_in    = bId[boardIdx];
    assign score_in = bScore[boardIdx];
    assign ptr_in   = bPtr[boardIdx];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearBoard();
        for (int i = 0; i < NENT; i++) begin
            bId[i] = '0;
            bScore[i] = 16'd5;
            bPtr[i] = 1'b0;
        end
    endtask

    // kind 0: random length, 1: full board random, 2: full board all pointer hits
    task automatic fillBoard(input int kind);
        int len;
        int sel;
        len = (kind == 0) ? int'($urandom_range(0, NENT)) : NENT;
        for (int i = 0; i < NENT; i++) begin
            bId[i] = (i < len) ? ID_LEN'($urandom_range(1, MAXID)) : '0;
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: bScore[i] = 16'd5;
                1: bScore[i] = 16'hFFEF;
                2: bScore[i] = 16'hFFF0;
                3: bScore[i] = 16'hFFFF;
                default: bScore[i] = SCORE_LEN'($urandom_range(0, 16'hFFEF));
            endcase
            bPtr[i] = (kind == 2) ? 1'b1 : ($urandom_range(0, 3) == 0);
        end
    endtask

    // Frame-level reference: scan entries in order until an empty slot.
    task automatic buildExpected(input bit conflict);
        logic flg;
        logic [7:0] id;
        expQ.delete();
        for (int i = 0; i < NENT; i++) begin
            if (bId[i] == '0) break;
            flg = bPtr[i] || (bScore[i] >= TH) || conflict;
            if (flg) begin
                id = 8'(modelNext);
                modelNext = (modelNext == MAXID) ? 1 : modelNext + 1;
            end else begin
                id = bId[i];
            end
            expQ.push_back({flg, id});
        end
    endtask

    task automatic applyStimulus(input bit conflict, input int mode, input bit inject);
        int n;
        int cycles;
        bit doneSeen;
        buildExpected(conflict);
        n = expQ.size();
        capLog.delete();
        readyMode = mode;
        stallCnt = 0;
        @(negedge clk);
        start_ida = 1'b1;
        conflict_counter_th = conflict;
        @(negedge clk);
        start_ida = 1'b0;
        conflict_counter_th = 1'($urandom_range(0, 1));
        cycles = 1;
        doneSeen = 0;
        while (cycles < 400) begin
            if (done_ida) begin
                doneSeen = 1;
                break;
            end
            start_ida = inject && (n >= 2) && (cycles == 3);
            @(negedge clk);
            cycles++;
        end
        start_ida = 1'b0;
        checkOutput("doneSeen", 32'(doneSeen), 32'd1);
        if (mode == 0)
            checkOutput("doneLatency", 32'(cycles), (n == NENT) ? 32'(2 * n + 1) : 32'(2 * n + 2));
        checkOutput("bboxCount", 32'(bbox_count), 32'(n));
        checkOutput("allEmitted", 32'(expQ.size()), 32'd0);
        @(negedge clk);
        checkOutput("donePulseWidth", 32'(done_ida), 32'd0);
        checkOutput("idleValid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("bboxHold", 32'(bbox_count), 32'(n));
    endtask

    // Ready pattern: 0 always ready, 1 random, 2 stall the first box five cycles.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid && stallCnt < 5) begin
                    out_ready = 1'b0;
                    stallCnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // Every cycle with a valid result is checked against the reference head;
    // a stalled result must stay put along with the PE address.
    always @(negedge clk) begin
        if (reset_N) begin
            if (prevStall) begin
                checkOutput("stallValid", 32'(out_valid), 32'd1);
                checkOutput("stallId", 32'(id_out), 32'(prevId));
                checkOutput("stallPe", 32'(pe_sel), 32'(prevPe));
            end
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'd1, 32'd0);
                end else begin
                    checkOutput("idOut", 32'(id_out), 32'(expQ[0][7:0]));
                    checkOutput("newIdFlg", 32'(new_id_flg), 32'(expQ[0][8]));
                    if (out_ready) begin
                        capLog.push_back({new_id_flg, id_out});
                        if (new_id_flg) newIds.push_back(int'(id_out));
                        void'(expQ.pop_front());
                    end
                end
            end
            prevStall = out_valid && !out_ready;
            prevId = id_out;
            prevPe = pe_sel;
        end else begin
            prevStall = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wrapIdx;
        clearBoard();
        #3;
        checkOutput("rstRowSel", 32'(row_sel), 32'd0);
        checkOutput("rstIdOut", 32'(id_out), 32'd0);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstDone", 32'(done_ida), 32'd0);
        checkOutput("rstBbox", 32'(bbox_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_N = 1'b1;

        // Pointer hit, score exactly at threshold, score just below threshold.
        clearBoard();
        bId[0] = 8'd7;  bPtr[0] = 1'b1;
        bId[1] = 8'd9;  bScore[1] = 16'hFFF0;
        bId[2] = 8'd5;  bScore[2] = 16'hFFEF;
        applyStimulus(0, 0, 0);
        checkOutput("litPtrBox", 32'(capLog[0]), 32'h101);
        checkOutput("litThBox", 32'(capLog[1]), 32'h102);
        checkOutput("litBelowTh", 32'(capLog[2]), 32'h005);

        clearBoard();
        bId[0] = 8'd11; bId[1] = 8'd12; bId[2] = 8'd13;
        applyStimulus(0, 0, 0);
        checkOutput("litKeep0", 32'(capLog[0]), 32'h00B);
        checkOutput("litKeep2", 32'(capLog[2]), 32'h00D);

        clearBoard();
        bId[0] = 8'd20; bId[1] = 8'd21;
        applyStimulus(1, 0, 0);
        checkOutput("litConflict0", 32'(capLog[0]), 32'h103);
        checkOutput("litConflict1", 32'(capLog[1]), 32'h104);

        clearBoard();
        bId[0] = 8'd30; bId[1] = 8'd31;
        applyStimulus(0, 2, 0);
        checkOutput("stallCount", 32'(stallCnt), 32'd5);

        fillBoard(1);
        applyStimulus(0, 0, 1);

        for (int f = 0; f < 20; f++) begin
            fillBoard(int'($urandom_range(0, 1)));
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        for (int f = 0; f < 18; f++) begin
            fillBoard(2);
            applyStimulus(0, 0, 0);
        end
        wrapIdx = -1;
        for (int i = 0; i + 1 < newIds.size(); i++) begin
            if (newIds[i] == MAXID) begin
                wrapIdx = i;
                break;
            end
        end
        checkOutput("wrapSeen", 32'(wrapIdx >= 0), 32'd1);
        if (wrapIdx >= 0) checkOutput("wrapToOne", 32'(newIds[wrapIdx + 1]), 32'd1);

        // Abort a scan with reset, then restart from the first board entry.
        fillBoard(1);
        buildExpected(0);
        @(negedge clk);
        start_ida = 1'b1;
        @(negedge clk);
        start_ida = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset_N = 1'b0;
        #1;
        checkOutput("midRstRow", 32'(row_sel), 32'd0);
        checkOutput("midRstPe", 32'(pe_sel), 32'd0);
        checkOutput("midRstId", 32'(id_out), 32'd0);
        checkOutput("midRstFlg", 32'(new_id_flg), 32'd0);
        checkOutput("midRstValid", 32'(out_valid), 32'd0);
        checkOutput("midRstDone", 32'(done_ida), 32'd0);
        checkOutput("midRstBbox", 32'(bbox_count), 32'd0);
        expQ.delete();
        newIds.delete();
        modelNext = 1;
        @(negedge clk);
        reset_N = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("noDoneAfterRst", 32'(done_ida), 32'd0);
            checkOutput("noValidAfterRst", 32'(out_valid), 32'd0);
        end
        fillBoard(1);
        bId[0] = 8'd42;
        bPtr[0] = 1'b1;
        applyStimulus(0, 0, 0);
        checkOutput("restartFirstBox", 32'(capLog[0]), 32'h101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oflow_id_assign_fsm.md
OFLOW_ID_ASSIGN_FSM -- requirements
Module: oflow_id_assign_fsm

Interface
REQ-001 SHALL have parameter SCORE_TH, default 16'hFFF0, the score at or above which a match is rejected.
REQ-002 SHALL have ports clk (input, 1) and reset_N (input, 1); one clock, reset asynchronous, active-low.
REQ-003 SHALL have port start_ida (input, 1): one-cycle pulse that starts a frame scan; typically driven from done_cr.
REQ-004 SHALL have port conflict_counter_th (input, 1): the conflict-resolve overflow flag, sampled with start_ida.
REQ-005 SHALL have ports row_sel (output, ROW_LEN) and pe_sel (output, PE_LEN): score_board read address.
REQ-006 SHALL have ports id_in, score_in and ptr_in (inputs; ID_LEN, SCORE_LEN, 1): score_board read data, combinational for the current address.
REQ-007 SHALL have ports id_out (output, ID_LEN), new_id_flg (output, 1), out_valid (output, 1) and out_ready (input, 1): the result stream.
REQ-008 SHALL have ports done_ida (output, 1), a one-cycle end-of-scan pulse, and bbox_count (output, NUM_OF_BBOX_IN_FRAME_WIDTH), the number of boxes emitted.

Function
REQ-009 SHALL have states idle_st, read_st, emit_st and done_st.
REQ-010 In idle_st, start_ida SHALL clear the row and PE counters and bbox_count and go to read_st.
REQ-011 In read_st, row_sel and pe_sel SHALL equal the counters; id_in==0 SHALL end the frame and go to done_st.
REQ-012 In read_st, a nonzero id_in SHALL be registered into id_out with new_id_flg, and the FSM SHALL go to emit_st.
REQ-013 new_id_flg SHALL be 1 iff ptr_in==1, or score_in>=SCORE_TH, or the sampled conflict_counter_th==1.
REQ-014 When new_id_flg is 1, id_out SHALL be the next_id register, and next_id SHALL increment in the same cycle.
REQ-015 next_id SHALL reset to 1, persist across frames, and wrap from all-ones to 1, never 0.
REQ-016 In emit_st, out_valid SHALL be 1, and id_out and new_id_flg SHALL hold stable until out_ready==1.
REQ-017 An emit_st cycle with out_ready==1 SHALL increment bbox_count and advance the PE counter.
REQ-018 When the PE counter reaches PE_NUM-1, the advance SHALL clear it and increment the row counter.
REQ-019 After the advance, the FSM SHALL go to done_st if row MAX_ROWS_IN_SCORE_BOARD-1 has just completed, else to read_st.
REQ-020 done_st SHALL assert done_ida for exactly one cycle and return to idle_st; bbox_count SHALL hold until the next start_ida.
REQ-021 start_ida outside idle_st SHALL be ignored.
REQ-022 Throughput SHALL be one box per two cycles with out_ready held high; a box SHALL appear on out_valid one cycle after its read_st cycle.
REQ-023 out_valid SHALL never be asserted in idle_st, read_st or done_st.

Reset
REQ-024 reset_N low SHALL asynchronously force idle_st and next_id=1, and drive all of these outputs to 0: row_sel, pe_sel, id_out, new_id_flg, out_valid, done_ida, bbox_count.
REQ-025 reset_N low mid-scan SHALL abort the scan with no done_ida pulse; the next start_ida SHALL restart from row 0, PE 0.

Structure
REQ-026 ROW_LEN, PE_LEN, ID_LEN, SCORE_LEN, PE_NUM, MAX_ROWS_IN_SCORE_BOARD and NUM_OF_BBOX_IN_FRAME_WIDTH SHALL come from the shared core defines, not be redefined locally.
REQ-027 The state enum SHALL live in shared package oflow_ida_pkg.
REQ-028 next_id SHALL be implemented as sub-module oflow_id_allocator (inputs alloc and reset_N, output next_id, wrap-skip-zero).
REQ-029 All state and output registers SHALL be in clocked blocks; next-state and the new-ID decision SHALL be combinational.

Verification
REQ-030 Scan with 3 boxes (ptr_in=0, score 5), then id_in=0, out_ready=1 -> id_out matches board ids, new_id_flg=0, bbox_count=3, one done_ida pulse.
REQ-031 Box with ptr_in=1 on first frame after reset -> id_out=1, new_id_flg=1; the next rejected box -> id_out=2.
REQ-032 out_ready held low 5 cycles in emit_st -> out_valid stays 1 and id_out unchanged; the PE counter advances only on the ready cycle.
REQ-033 conflict_counter_th=1 at start_ida with 2 boxes -> both new_id_flg=1 with consecutive next_id values.
REQ-034 Full board (all PE_NUM x MAX_ROWS entries nonzero) -> bbox_count=PE_NUM*MAX_ROWS_IN_SCORE_BOARD; row/PE wrap is correct; done_ida fires after the last entry.
REQ-035 Preload next_id to all-ones and allocate twice -> ids all-ones, then 1; separately, reset_N pulsed mid-scan -> idle_st, no done_ida, outputs 0.
